// File: rtl/osd_stm_trace_arb.sv
// Round-robin arbiter sharing one STM trace event port between NUM_SRC sources.
// Optional in-band overflow reporting is enabled with `define OSD_STM_ARB_OVF_EVENT_EN.
module osd_stm_trace_arb #(
  parameter int          NUM_SRC = 4,
  parameter logic [15:0] OVF_ID  = 16'hFFFF,
  parameter int          CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*16-1:0]    src_id,
  input  logic [NUM_SRC*64-1:0]    src_value,
  output logic                     trace_valid,
  output logic [15:0]              trace_id,
  output logic [63:0]              trace_value,
  output logic [NUM_SRC*CNT_W-1:0] ovf_count,
  input  logic [NUM_SRC-1:0]       ovf_clr,
  output logic                     busy
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] occupied_reg;
  logic [15:0]        hold_id_reg    [NUM_SRC];
  logic [63:0]        hold_value_reg [NUM_SRC];
  logic [CNT_W-1:0]   cnt_reg        [NUM_SRC];
  logic [PTR_W-1:0]   ptr_reg;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] ovf_pend;
  logic [NUM_SRC-1:0] load;
  logic [NUM_SRC-1:0] consume;
  logic [NUM_SRC-1:0] drop;
  logic [NUM_SRC-1:0] ovf_sel;
  logic               grant_valid;
  logic [PTR_W-1:0]   grant_idx;
  logic [15:0]        sel_id;
  logic [63:0]        sel_value;

  // Per-source capture decisions: a granted held event frees its slot for a same-cycle load.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic granted;
    logic fire;

`ifdef OSD_STM_ARB_OVF_EVENT_EN
    assign ovf_pend[gi] = (cnt_reg[gi] != '0);
`else
    assign ovf_pend[gi] = 1'b0;
`endif

    assign granted     = grant_valid && (grant_idx == PTR_W'(gi));
    assign fire        = src_en[gi] & src_valid[gi];
    assign ovf_sel[gi] = granted & ovf_pend[gi];
    assign consume[gi] = granted & ~ovf_pend[gi];
    assign load[gi]    = fire & (~occupied_reg[gi] | consume[gi]);
    assign drop[gi]    = fire & ~load[gi];
    assign req[gi]     = occupied_reg[gi] | ovf_pend[gi];
    assign ovf_count[gi*CNT_W +: CNT_W] = cnt_reg[gi];
  end

  // Scan from farthest to nearest so the first requester at or after ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    sel_id    = hold_id_reg[grant_idx];
    sel_value = hold_value_reg[grant_idx];
    if (ovf_pend[grant_idx]) begin
      sel_id    = OVF_ID;
      sel_value = {32'h0, 16'(grant_idx), 16'(cnt_reg[grant_idx])};
    end
  end

  assign busy = |occupied_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied_reg <= '0;
      ptr_reg      <= '0;
      trace_valid  <= 1'b0;
      trace_id     <= '0;
      trace_value  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_id_reg[i]    <= '0;
        hold_value_reg[i] <= '0;
        cnt_reg[i]        <= '0;
      end
    end else begin
      trace_valid <= grant_valid;
      if (grant_valid) begin
        trace_id    <= sel_id;
        trace_value <= sel_value;
        ptr_reg     <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        occupied_reg[i] <= load[i] | (occupied_reg[i] & ~consume[i]);
        if (load[i]) begin
          hold_id_reg[i]    <= src_id[16*i +: 16];
          hold_value_reg[i] <= src_value[64*i +: 64];
        end
        // A clear or a reported overflow restarts the count, keeping a same-cycle drop.
        if (ovf_clr[i] || ovf_sel[i]) begin
          cnt_reg[i] <= drop[i] ? CNT_W'(1) : '0;
        end else if (drop[i] && (cnt_reg[i] != '1)) begin
          cnt_reg[i] <= cnt_reg[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_osd_stm_trace_arb.sv
// Scoreboard bench for osd_stm_trace_arb: stimulus pushes expected trace events,
// a negedge monitor pops and compares them; direct checks cover counters and busy.
module tb_osd_stm_trace_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   src_en;
  logic [3:0]   src_valid;
  logic [63:0]  src_id;
  logic [255:0] src_value;
  logic [3:0]   ovf_clr;
  logic         trace_valid;
  logic [15:0]  trace_id;
  logic [63:0]  trace_value;
  logic [63:0]  ovf_count;
  logic         busy;

  // Narrow-counter instance used for the saturation/clear checks.
  logic [3:0]   sat_valid;
  logic [3:0]   sat_clr;
  logic         sat_tv;
  logic [15:0]  sat_tid;
  logic [63:0]  sat_tval;
  logic [31:0]  sat_count;
  logic         sat_busy;

  int total = 0;
  int bad   = 0;
  logic [79:0] exp_q[$];

  always #5 clk = ~clk;

  osd_stm_trace_arb #(.NUM_SRC(4), .OVF_ID(16'hFFFF), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .src_en(src_en), .src_valid(src_valid),
    .src_id(src_id), .src_value(src_value), .trace_valid(trace_valid),
    .trace_id(trace_id), .trace_value(trace_value), .ovf_count(ovf_count),
    .ovf_clr(ovf_clr), .busy(busy)
  );

  osd_stm_trace_arb #(.NUM_SRC(4), .OVF_ID(16'hFFFF), .CNT_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .src_en(4'hF), .src_valid(sat_valid),
    .src_id(64'h0), .src_value(256'h0), .trace_valid(sat_tv),
    .trace_id(sat_tid), .trace_value(sat_tval), .ovf_count(sat_count),
    .ovf_clr(sat_clr), .busy(sat_busy)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every trace_valid cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && trace_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got id=%h value=%h expected none", trace_id, trace_value);
      end else begin
        logic [79:0] e;
        e = exp_q.pop_front();
        if ({trace_id, trace_value} !== e) begin
          bad++;
          $display("FAIL trace_event: got id=%h value=%h expected id=%h value=%h",
                   trace_id, trace_value, e[79:64], e[63:0]);
        end else begin
          $display("trace id=%h value=%h", trace_id, trace_value);
        end
      end
    end
  end

  task automatic set_ev(input int s, input logic [15:0] id, input logic [63:0] v);
    src_valid[s]          = 1'b1;
    src_id[16*s +: 16]    = id;
    src_value[64*s +: 64] = v;
  endtask

  task automatic push(input logic [15:0] id, input logic [63:0] v);
    exp_q.push_back({id, v});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    chk("queue_drained", 80'(exp_q.size()), 80'd0);
    exp_q.delete();
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    src_en    = 4'hF;
    src_valid = '0;
    src_id    = '0;
    src_value = '0;
    ovf_clr   = '0;
    sat_valid = '0;
    sat_clr   = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_trace_valid", 80'(trace_valid), 80'd0);
    chk("rst_trace_id", 80'(trace_id), 80'd0);
    chk("rst_trace_value", 80'(trace_value), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_ovf_count", 80'(ovf_count), 80'd0);
    step(2);
    rst_n = 1'b1;

    // Single source, two-cycle latency.
    set_ev(2, 16'h0012, 64'hDEAD_BEEF);
    push(16'h0012, 64'hDEAD_BEEF);
    step(1);
    src_valid = '0;
    chk("single_busy_held", 80'(busy), 80'd1);
    chk("single_not_yet", 80'(trace_valid), 80'd0);
    step(1);
    chk("single_busy_clear", 80'(busy), 80'd0);
    chk("single_valid", 80'(trace_valid), 80'd1);
    step(1);
    chk("single_pulse", 80'(trace_valid), 80'd0);
    chk("single_no_drops", 80'(ovf_count), 80'd0);
    step(2);

    // Collision from ptr=0: ids 0..3 drain in order, no drops.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_ev(i, 16'(i), 64'h1000 + 64'(i));
      push(16'(i), 64'h1000 + 64'(i));
    end
    step(1);
    src_valid = '0;
    step(6);
    chk("collision_no_drops", 80'(ovf_count), 80'd0);
    chk("collision_idle", 80'(busy), 80'd0);

    // Disabled source is ignored entirely.
    do_reset();
    src_en = 4'b0111;
    set_ev(3, 16'h0333, 64'h3333);
    step(1);
    src_valid = '0;
    step(4);
    chk("disabled_no_count", 80'(ovf_count), 80'd0);
    chk("disabled_not_busy", 80'(busy), 80'd0);
    // Held event still delivered after its enable drops.
    src_en = 4'hF;
    set_ev(2, 16'h0222, 64'h2222);
    push(16'h0222, 64'h2222);
    step(1);
    src_valid = '0;
    src_en    = 4'b1011;
    step(3);
    src_en = 4'hF;

    // Reset while two events are held: nothing stale afterwards.
    do_reset();
    set_ev(0, 16'h0A00, 64'hA0);
    set_ev(1, 16'h0A01, 64'hA1);
    set_ev(2, 16'h0A02, 64'hA2);
    push(16'h0A00, 64'hA0);
    step(1);
    src_valid = '0;
    step(1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid_low", 80'(trace_valid), 80'd0);
    chk("midrst_busy_low", 80'(busy), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8);

`ifndef OSD_STM_ARB_OVF_EVENT_EN
    // Sources 1 and 3 fire for 20 cycles: alternate grants, drops on the loser.
    do_reset();
    push(16'h0100, 64'hA100);
    push(16'h0300, 64'hA300);
    for (int j = 1; j < 20; j++) begin
      if (j % 2 == 1) push({8'h01, 8'(j)}, 64'hA100 + 64'(j));
      else            push({8'h03, 8'(j)}, 64'hA300 + 64'(j));
    end
    for (int c = 0; c < 20; c++) begin
      set_ev(1, {8'h01, 8'(c)}, 64'hA100 + 64'(c));
      set_ev(3, {8'h03, 8'(c)}, 64'hA300 + 64'(c));
      step(1);
    end
    src_valid = '0;
    step(5);
    chk("rr_drops_src0", 80'(ovf_count[15:0]), 80'd0);
    chk("rr_drops_src1", 80'(ovf_count[31:16]), 80'd9);
    chk("rr_drops_src3", 80'(ovf_count[63:48]), 80'd10);

    // Saturation then clear on the narrow-counter instance.
    do_reset();
    sat_valid = 4'hF;
    step(400);
    chk("sat_count_max", 80'(sat_count[7:0]), 80'hFF);
    sat_clr = 4'b0001;
    step(1);
    sat_clr = '0;
    chk("sat_clr_with_drop", 80'(sat_count[7:0]), 80'd1);
    sat_valid = '0;
    sat_clr   = 4'b0001;
    step(1);
    sat_clr = '0;
    chk("sat_clr_alone", 80'(sat_count[7:0]), 80'd0);
    step(6);
`else
    // One drop on source 0 is reported in-band before its held event.
    do_reset();
    set_ev(0, 16'h00B0, 64'hB0);
    set_ev(1, 16'h00A1, 64'hA1);
    push(16'h00B0, 64'hB0);
    push(16'h00A1, 64'hA1);
    push(16'hFFFF, 64'h0000_0000_0000_0001);
    push(16'h00B1, 64'hB1);
    step(1);
    src_valid[1] = 1'b0;
    set_ev(0, 16'h00B1, 64'hB1);
    step(1);
    set_ev(0, 16'h00B2, 64'hB2);
    step(1);
    src_valid = '0;
    chk("ovf_one_drop", 80'(ovf_count[15:0]), 80'd1);
    step(1);
    chk("ovf_reported_clear", 80'(ovf_count[15:0]), 80'd0);
    chk("ovf_held_still_busy", 80'(busy), 80'd1);
    step(5);
    chk("ovf_all_idle", 80'(busy), 80'd0);
`endif

    chk("queue_empty_end", 80'(exp_q.size()), 80'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
